// File: rtl/tlb_refill_arbiter.sv
// tlb_refill_arbiter: shares the single TLB search port between the ITLB and
// DTLB refill buffers and the MEM-stage TLB management instructions.
// A refill lookup takes LOOKUP then RESP. A management op takes one MGMT cycle.
// A TLB write (TLBWI/TLBWR) is followed by a flush pulse to both buffers.
// Build option: define TLB_ARB_RR_EN for round-robin between ITLB and DTLB.
// When it is undefined, the DTLB request always wins.
module tlb_refill_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [18:0] i_vpn2,
  input  logic        d_req,
  input  logic [18:0] d_vpn2,
  input  logic        mgmt_req,
  input  logic        mgmt_isw,
  input  logic        tlb_found,
  input  logic [77:0] tlb_entry,
  output logic [18:0] srch_vpn2,
  output logic        i_ack,
  output logic        d_ack,
  output logic        rsp_found,
  output logic [77:0] rsp_entry,
  output logic        mgmt_gnt,
  output logic        tlb_flush,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    MGMT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        win_d;
  logic        pick_d;
  logic [18:0] lat_vpn2;
  logic        start_lookup;

`ifdef TLB_ARB_RR_EN
  // rr_ptr = 1 means the DTLB has priority on the next tie.
  logic rr_ptr;

  // Choose the refill winner: a lone requester wins, and rr_ptr breaks a tie.
  always_comb begin
    pick_d = d_req && (!i_req || rr_ptr);
  end

  // After each response, hand priority to the requester that did not win.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == RESP) begin
      rr_ptr <= ~win_d;
    end
  end
`else
  // Fixed priority: the DTLB wins whenever it is requesting.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // A refill starts only from IDLE, and only when no management op is waiting.
  always_comb begin
    start_lookup = (state == IDLE) && !mgmt_req && (i_req || d_req);
  end

  // Next-state logic. Once a lookup or a management op has started, it runs
  // to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mgmt_req) begin
          state_nxt = MGMT;
        end else if (i_req || d_req) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      MGMT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner and its VPN2 when a lookup starts.
  // The VPN2 is latched so the search port stays stable even if the
  // requester drops its request.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_d    <= 1'b0;
      lat_vpn2 <= '0;
    end else if (start_lookup) begin
      win_d    <= pick_d;
      lat_vpn2 <= pick_d ? d_vpn2 : i_vpn2;
    end
  end

  // Capture the search result at the end of LOOKUP.
  // The captured result holds until the next lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_found <= 1'b0;
      rsp_entry <= '0;
    end else if (state == LOOKUP) begin
      rsp_found <= tlb_found;
      rsp_entry <= tlb_entry;
    end
  end

  // Pulse the flush in the cycle after a TLB write has been granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_flush <= 1'b0;
    end else begin
      tlb_flush <= (state == MGMT) && mgmt_isw;
    end
  end

  // Decode the strobes from the state. They are masked by rst, so an
  // aborted operation never shows an ack or a grant.
  always_comb begin
    srch_vpn2 = lat_vpn2;
    i_ack     = (state == RESP) && !win_d && !rst;
    d_ack     = (state == RESP) &&  win_d && !rst;
    mgmt_gnt  = (state == MGMT) && !rst;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// tb_tlb_refill_arbiter: directed vectors with hand-computed expectations for
// tlb_refill_arbiter. It follows the TLB_ARB_RR_EN build option of the design.
module tb_tlb_refill_arbiter;

`ifdef TLB_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [18:0] i_vpn2;
  logic        d_req;
  logic [18:0] d_vpn2;
  logic        mgmt_req;
  logic        mgmt_isw;
  logic        tlb_found;
  logic [77:0] tlb_entry;
  logic [18:0] srch_vpn2;
  logic        i_ack;
  logic        d_ack;
  logic        rsp_found;
  logic [77:0] rsp_entry;
  logic        mgmt_gnt;
  logic        tlb_flush;
  logic        busy;

  // Flag bits, from MSB to LSB: {i_ack, d_ack, mgmt_gnt, tlb_flush, busy}.
  logic [4:0]  flags;

  int checks;
  int failures;

  localparam logic [77:0] ENTRY_A = 78'h0ABCD_1234_5678_9ABC_DE;

  tlb_refill_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_vpn2    (i_vpn2),
    .d_req     (d_req),
    .d_vpn2    (d_vpn2),
    .mgmt_req  (mgmt_req),
    .mgmt_isw  (mgmt_isw),
    .tlb_found (tlb_found),
    .tlb_entry (tlb_entry),
    .srch_vpn2 (srch_vpn2),
    .i_ack     (i_ack),
    .d_ack     (d_ack),
    .rsp_found (rsp_found),
    .rsp_entry (rsp_entry),
    .mgmt_gnt  (mgmt_gnt),
    .tlb_flush (tlb_flush),
    .busy      (busy)
  );

  assign flags = {i_ack, d_ack, mgmt_gnt, tlb_flush, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [18:0] iv, input logic dr,
                               input logic [18:0] dv, input logic mr, input logic mw,
                               input logic fnd, input logic [77:0] ent);
    i_req     = ir;
    i_vpn2    = iv;
    d_req     = dr;
    d_vpn2    = dv;
    mgmt_req  = mr;
    mgmt_isw  = mw;
    tlb_found = fnd;
    tlb_entry = ent;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, 0, 0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, 0, 0, '0);

    // Reset state.
    doReset();
    checkOutput("reset_flags", flags, 5'b00000);
    checkOutput("reset_rsp_found", rsp_found, 1'b0);
    checkOutput("reset_rsp_entry", rsp_entry, 78'h0);
    checkOutput("reset_srch", srch_vpn2, 19'h0);

    // Single ITLB refill that hits.
    applyStimulus(1, 19'h00123, 0, 19'h0, 0, 0, 1, ENTRY_A);
    tick();
    checkOutput("i_lookup_srch", srch_vpn2, 19'h00123);
    checkOutput("i_lookup_flags", flags, 5'b00001);
    tick();
    checkOutput("i_resp_flags", flags, 5'b10001);
    checkOutput("i_resp_found", rsp_found, 1'b1);
    checkOutput("i_resp_entry", rsp_entry, ENTRY_A);
    applyStimulus(0, 19'h00123, 0, 19'h0, 0, 0, 0, 78'h0);
    tick();
    checkOutput("i_idle_flags", flags, 5'b00000);
    tick();
    checkOutput("rsp_found_hold", rsp_found, 1'b1);
    checkOutput("rsp_entry_hold", rsp_entry, ENTRY_A);

    // ITLB and DTLB both requesting continuously from reset.
    doReset();
    applyStimulus(1, 19'h1AAAA, 1, 19'h05555, 0, 0, 0, '0);
    for (int c = 1; c <= 12; c++) begin
      int  g;
      bit  exp_d;
      tick();
      g     = c / 3;
      exp_d = RR_EN ? (g % 2 == 1) : 1'b1;
      checkOutput($sformatf("both_busy_c%0d", c), busy, (c % 3) != 0);
      if (c % 3 == 2) begin
        checkOutput($sformatf("both_ack_c%0d", c), {i_ack, d_ack}, exp_d ? 2'b01 : 2'b10);
      end else begin
        checkOutput($sformatf("both_noack_c%0d", c), {i_ack, d_ack}, 2'b00);
      end
      if (c % 3 == 1) begin
        checkOutput($sformatf("both_srch_c%0d", c), srch_vpn2, exp_d ? 19'h05555 : 19'h1AAAA);
      end
    end

    // A TLB write wins over a pending DTLB request, then the refill proceeds.
    doReset();
    applyStimulus(0, '0, 1, 19'h7FFFF, 1, 1, 0, '0);
    tick();
    checkOutput("mgmt_gnt_flags", flags, 5'b00101);
    mgmt_req = 1'b0;
    tick();
    checkOutput("mgmt_flush_flags", flags, 5'b00010);
    tick();
    checkOutput("mgmt_d_lookup_flags", flags, 5'b00001);
    checkOutput("mgmt_d_lookup_srch", srch_vpn2, 19'h7FFFF);
    tick();
    checkOutput("mgmt_d_resp_flags", flags, 5'b01001);
    checkOutput("mgmt_d_resp_found", rsp_found, 1'b0);
    d_req = 1'b0;
    tick();
    checkOutput("mgmt_d_idle_flags", flags, 5'b00000);
    // A TLBP/TLBR is granted but produces no flush.
    mgmt_req = 1'b1;
    mgmt_isw = 1'b0;
    tick();
    checkOutput("probe_gnt_flags", flags, 5'b00101);
    mgmt_req = 1'b0;
    tick();
    checkOutput("probe_noflush_flags", flags, 5'b00000);

    // mgmt_req arrives during a lookup; the winner drops its request early.
    doReset();
    applyStimulus(0, 19'h00042, 1, 19'h00777, 0, 0, 1, ENTRY_A);
    tick();
    checkOutput("late_mgmt_lookup_flags", flags, 5'b00001);
    applyStimulus(1, 19'h00042, 0, 19'h00777, 1, 0, 1, ENTRY_A);
    tick();
    checkOutput("late_mgmt_dack_flags", flags, 5'b01001);
    tick();
    checkOutput("late_mgmt_idle_flags", flags, 5'b00000);
    tick();
    checkOutput("late_mgmt_gnt_flags", flags, 5'b00101);
    mgmt_req = 1'b0;
    tick();
    checkOutput("late_mgmt_after_flags", flags, 5'b00000);
    tick();
    checkOutput("late_i_lookup_srch", srch_vpn2, 19'h00042);
    tick();
    checkOutput("late_i_ack_flags", flags, 5'b10001);
    i_req = 1'b0;

    // Reset in the middle of a lookup aborts it without an ack.
    doReset();
    applyStimulus(0, '0, 1, 19'h03C3C, 0, 0, 1, ENTRY_A);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_lookup_noack", {i_ack, d_ack}, 2'b00);
    tick();
    rst   = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("abort_lookup_flags", flags, 5'b00000);
    checkOutput("abort_lookup_found", rsp_found, 1'b0);
    checkOutput("abort_lookup_entry", rsp_entry, 78'h0);
    checkOutput("abort_lookup_srch", srch_vpn2, 19'h0);
    tick();
    checkOutput("abort_lookup_later", flags, 5'b00000);

    // Reset during a TLB write grant aborts it without a grant or a flush.
    doReset();
    applyStimulus(0, '0, 0, '0, 1, 1, 0, '0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_mgmt_nognt", mgmt_gnt, 1'b0);
    tick();
    rst      = 1'b0;
    mgmt_req = 1'b0;
    #1;
    checkOutput("abort_mgmt_noflush", flags, 5'b00000);
    tick();
    checkOutput("abort_mgmt_later", flags, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
